// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM geometry, GP0 opcodes and the CPU->VRAM sequencer state encoding.
package gpu_pkg;

   localparam int unsigned VRAM_X_W = 10;
   localparam int unsigned VRAM_Y_W = 9;

   localparam logic [7:0] GP0_OP_CPU2VRAM = 8'hA0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_PIX_LO = 3'd2,
      ST_PIX_HI = 3'd3,
      ST_DONE   = 3'd4
   } xfer_state_e;

   // Force the mask bit (bit15) of a pixel when the set-mask mode is on.
   function automatic logic [15:0] apply_set_mask(input logic [15:0] px, input logic set_mask);
      return {px[15] | set_mask, px[14:0]};
   endfunction

endpackage

// File: rtl/gpu_rect_walker.sv
// Rectangle walker: latches origin and normalised size, steps x/y counters row-major and
// produces the wrapped VRAM address plus a last-pixel flag.
module gpu_rect_walker
   import gpu_pkg::*;
#(
   parameter int unsigned X_W = VRAM_X_W,
   parameter int unsigned Y_W = VRAM_Y_W
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           load_i,
   input  logic           step_i,
   input  logic [X_W-1:0] x0_i,
   input  logic [Y_W-1:0] y0_i,
   input  logic [X_W:0]   w_i,
   input  logic [Y_W:0]   h_i,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
   output logic           last_o
);

   logic [X_W-1:0] x0_q, x0_d;
   logic [Y_W-1:0] y0_q, y0_d;
   logic [X_W:0]   w_q, w_d, xc_q, xc_d;
   logic [Y_W:0]   h_q, h_d, yc_q, yc_d;
   logic [X_W-1:0] w_m1;
   logic [Y_W-1:0] h_m1;
   logic           x_end;

   // A raw size of 0 (or any value above the VRAM extent) folds into 1..max.
   assign w_m1  = X_W'(w_i - (X_W+1)'(1));
   assign h_m1  = Y_W'(h_i - (Y_W+1)'(1));
   assign x_end = (xc_q == w_q - (X_W+1)'(1));

   always_comb begin
      x0_d = x0_q;
      y0_d = y0_q;
      w_d  = w_q;
      h_d  = h_q;
      xc_d = xc_q;
      yc_d = yc_q;
      if (load_i) begin
         x0_d = x0_i;
         y0_d = y0_i;
         w_d  = (X_W+1)'(w_m1) + (X_W+1)'(1);
         h_d  = (Y_W+1)'(h_m1) + (Y_W+1)'(1);
         xc_d = '0;
         yc_d = '0;
      end else if (step_i) begin
         if (x_end) begin
            xc_d = '0;
            yc_d = yc_q + (Y_W+1)'(1);
         end else begin
            xc_d = xc_q + (X_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x0_q <= '0;
         y0_q <= '0;
         w_q  <= '0;
         h_q  <= '0;
         xc_q <= '0;
         yc_q <= '0;
      end else begin
         x0_q <= x0_d;
         y0_q <= y0_d;
         w_q  <= w_d;
         h_q  <= h_d;
         xc_q <= xc_d;
         yc_q <= yc_d;
      end
   end

   // Only the low bits are kept so the address wraps at the VRAM edge.
   assign x_o    = X_W'(x0_q + xc_q[X_W-1:0]);
   assign y_o    = Y_W'(y0_q + yc_q[Y_W-1:0]);
   assign last_o = x_end && (yc_q == h_q - (Y_W+1)'(1));

endmodule

// File: rtl/gpu_mem_cpuvram_ctrl.sv
// GP0 A0h CPU->VRAM copy sequencer: drains 32-bit FIFO words as two 16-bit pixel writes
// into a wrapped VRAM rectangle.
module gpu_mem_cpuvram_ctrl
   import gpu_pkg::*;
#(
   parameter int unsigned X_W = VRAM_X_W,
   parameter int unsigned Y_W = VRAM_Y_W
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           start_i,
   input  logic           abort_i,
   input  logic [X_W-1:0] x0_i,
   input  logic [Y_W-1:0] y0_i,
   input  logic [X_W:0]   w_i,
   input  logic [Y_W:0]   h_i,
   input  logic           set_mask_i,
   input  logic           chk_mask_i,
   input  logic [31:0]    fifo_data_i,
   input  logic           fifo_valid_i,
   output logic           fifo_pop_o,
   output logic           mem_req_o,
   input  logic           mem_ack_i,
   output logic [X_W-1:0] mem_x_o,
   output logic [Y_W-1:0] mem_y_o,
   output logic [15:0]    mem_data_o,
   output logic           mem_chk_o,
   output logic           busy_o,
   output logic           done_o
);

   xfer_state_e    state_q, state_d;
   logic           set_mask_q, set_mask_d;
   logic           chk_q, chk_d;
   logic           accept_c, req_c, ack_c, last_c;
   logic [X_W-1:0] wx_c;
   logic [Y_W-1:0] wy_c;
   logic [15:0]    px_c;

   assign accept_c = (state_q == ST_IDLE) && start_i && !abort_i;
   // PIX_LO may be entered straight after a pop, so it only requests once a head word exists.
   assign req_c    = (state_q == ST_PIX_HI) || ((state_q == ST_PIX_LO) && fifo_valid_i);
   assign ack_c    = req_c && mem_ack_i;

   gpu_rect_walker #(
      .X_W (X_W),
      .Y_W (Y_W)
   ) u_walker (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (accept_c),
      .step_i (ack_c),
      .x0_i   (x0_i),
      .y0_i   (y0_i),
      .w_i    (w_i),
      .h_i    (h_i),
      .x_o    (wx_c),
      .y_o    (wy_c),
      .last_o (last_c)
   );

   always_comb begin
      state_d    = state_q;
      set_mask_d = set_mask_q;
      chk_d      = chk_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               state_d    = ST_WAIT;
               set_mask_d = set_mask_i;
               chk_d      = chk_mask_i;
            end
         end
         ST_WAIT: begin
            if (fifo_valid_i) state_d = ST_PIX_LO;
         end
         ST_PIX_LO: begin
            if (ack_c) state_d = last_c ? ST_DONE : ST_PIX_HI;
         end
         ST_PIX_HI: begin
            if (ack_c) begin
               if (last_c)            state_d = ST_DONE;
               else if (fifo_valid_i) state_d = ST_PIX_LO;
               else                   state_d = ST_WAIT;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (abort_i) state_d = ST_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         set_mask_q <= 1'b0;
         chk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         set_mask_q <= set_mask_d;
         chk_q      <= chk_d;
      end
   end

   // Pixel data comes straight from the FIFO head; the word is popped on its last accepted pixel.
   assign px_c       = (state_q == ST_PIX_HI) ? fifo_data_i[31:16] : fifo_data_i[15:0];
   assign mem_req_o  = req_c;
   assign mem_x_o    = req_c ? wx_c : '0;
   assign mem_y_o    = req_c ? wy_c : '0;
   assign mem_data_o = req_c ? apply_set_mask(px_c, set_mask_q) : 16'h0000;
   assign mem_chk_o  = req_c && chk_q;
   assign fifo_pop_o = ack_c && ((state_q == ST_PIX_HI) || last_c);
   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_gpu_mem_cpuvram_ctrl.sv
// Randomized bench for the CPU->VRAM copy sequencer against a rectangle/FIFO reference model.
module tb_gpu_mem_cpuvram_ctrl;

   localparam int unsigned X_W = 10;
   localparam int unsigned Y_W = 9;

   logic           clk_i = 1'b0;
   logic           rst_ni;
   logic           start_i, abort_i;
   logic [X_W-1:0] x0_i;
   logic [Y_W-1:0] y0_i;
   logic [X_W:0]   w_i;
   logic [Y_W:0]   h_i;
   logic           set_mask_i, chk_mask_i;
   logic [31:0]    fifo_data_i;
   logic           fifo_valid_i, fifo_pop_o;
   logic           mem_req_o, mem_ack_i;
   logic [X_W-1:0] mem_x_o;
   logic [Y_W-1:0] mem_y_o;
   logic [15:0]    mem_data_o;
   logic           mem_chk_o, busy_o, done_o;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int          x;
      int          y;
      logic [15:0] d;
   } wr_t;

   logic [31:0] src_q[$];
   int r_writes, r_pops, r_dones;

   gpu_mem_cpuvram_ctrl #(.X_W(X_W), .Y_W(Y_W)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .x0_i         (x0_i),
      .y0_i         (y0_i),
      .w_i          (w_i),
      .h_i          (h_i),
      .set_mask_i   (set_mask_i),
      .chk_mask_i   (chk_mask_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_valid_i (fifo_valid_i),
      .fifo_pop_o   (fifo_pop_o),
      .mem_req_o    (mem_req_o),
      .mem_ack_i    (mem_ack_i),
      .mem_x_o      (mem_x_o),
      .mem_y_o      (mem_y_o),
      .mem_data_o   (mem_data_o),
      .mem_chk_o    (mem_chk_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Runs one transfer of the words in src_q, checking every write, pop and done against the model.
   task automatic run_xfer(input int x0, input int y0, input int w, input int h,
                           input bit sm, input bit cm, input int depth, input int fifo_pct,
                           input int ack_pct, input int as_lo, input int as_hi,
                           input int fs_lo, input int fs_hi, input int abort_at);
      wr_t            exp_q[$];
      wr_t            e;
      logic [31:0]    fq[$];
      logic [31:0]    words[$];
      logic [31:0]    wd;
      logic [15:0]    half;
      int             wn, hn, idx, n, pops, dones, cyc, last_cyc, budget;
      bit             finished, pend, abort_now;
      logic [X_W-1:0] px;
      logic [Y_W-1:0] py;
      logic [15:0]    pdat;
      words = src_q;
      wn = ((w - 1) & 1023) + 1;
      hn = ((h - 1) & 511) + 1;
      for (int yc = 0; yc < hn; yc++) begin
         for (int xc = 0; xc < wn; xc++) begin
            idx  = yc * wn + xc;
            wd   = words[idx / 2];
            half = (idx % 2 == 1) ? wd[31:16] : wd[15:0];
            if (sm) half[15] = 1'b1;
            e.x = (x0 + xc) % 1024;
            e.y = (y0 + yc) % 512;
            e.d = half;
            exp_q.push_back(e);
         end
      end
      n = 0; pops = 0; dones = 0; cyc = 0; last_cyc = -10;
      finished = 0; pend = 0;
      px = '0; py = '0; pdat = '0;
      budget = 30 * exp_q.size() + 100;

      @(negedge clk_i);
      x0_i = X_W'(x0); y0_i = Y_W'(y0); w_i = (X_W+1)'(w); h_i = (Y_W+1)'(h);
      set_mask_i = sm; chk_mask_i = cm; start_i = 1'b1; abort_i = 1'b0;
      fifo_valid_i = 1'b0; mem_ack_i = 1'b0;

      while (!finished && cyc < budget) begin
         @(negedge clk_i);
         if (!(cyc >= fs_lo && cyc <= fs_hi) && words.size() > 0 && fq.size() < depth &&
             $urandom_range(99) < fifo_pct)
            fq.push_back(words.pop_front());
         fifo_valid_i = (fq.size() > 0);
         fifo_data_i  = fifo_valid_i ? fq[0] : $urandom;
         abort_now    = (abort_at >= 0 && n == abort_at);
         mem_ack_i    = !abort_now && !(cyc >= as_lo && cyc <= as_hi) && ($urandom_range(99) < ack_pct);
         abort_i      = abort_now;
         start_i      = ($urandom_range(7) == 0);
         x0_i = X_W'($urandom); y0_i = Y_W'($urandom);
         w_i = (X_W+1)'($urandom); h_i = (Y_W+1)'($urandom);
         set_mask_i = 1'($urandom); chk_mask_i = 1'($urandom);
         #1;
         tests++;
         if (busy_o !== 1'b1) begin
            fails++; $display("FAIL busy_during_xfer: cyc=%0d got %b expected 1", cyc, busy_o);
         end
         if (pend) begin
            tests++;
            if (mem_req_o !== 1'b1 || mem_x_o !== px || mem_y_o !== py || mem_data_o !== pdat) begin
               fails++;
               $display("FAIL req_hold: cyc=%0d got req=%b x=%0d y=%0d d=%h expected req=1 x=%0d y=%0d d=%h",
                        cyc, mem_req_o, mem_x_o, mem_y_o, mem_data_o, px, py, pdat);
            end
         end
         pend = 0;
         if (mem_req_o === 1'b1) begin
            tests++;
            if (fifo_valid_i !== 1'b1) begin
               fails++; $display("FAIL req_without_data: cyc=%0d got fifo_valid=%b expected 1", cyc, fifo_valid_i);
            end
            tests++;
            if (mem_chk_o !== cm) begin
               fails++; $display("FAIL chk: cyc=%0d got %b expected %b", cyc, mem_chk_o, cm);
            end
            if (mem_ack_i) begin
               tests++;
               if (n >= exp_q.size()) begin
                  fails++; $display("FAIL extra_write: got write #%0d expected only %0d", n, exp_q.size());
               end else if (mem_x_o !== X_W'(exp_q[n].x) || mem_y_o !== Y_W'(exp_q[n].y) ||
                            mem_data_o !== exp_q[n].d) begin
                  fails++;
                  $display("FAIL write%0d: got (%0d,%0d)=%h expected (%0d,%0d)=%h", n,
                           mem_x_o, mem_y_o, mem_data_o, exp_q[n].x, exp_q[n].y, exp_q[n].d);
               end
               n++;
               if (n == exp_q.size()) last_cyc = cyc;
            end else begin
               pend = 1; px = mem_x_o; py = mem_y_o; pdat = mem_data_o;
            end
         end
         if (fifo_pop_o === 1'b1) begin
            tests++;
            if (!(mem_ack_i && mem_req_o === 1'b1 && fq.size() > 0)) begin
               fails++; $display("FAIL spurious_pop: cyc=%0d got pop with ack=%b req=%b expected pop only on ack",
                                 cyc, mem_ack_i, mem_req_o);
            end
            if (fq.size() > 0) void'(fq.pop_front());
            pops++;
         end
         if (done_o === 1'b1) begin
            dones++;
            tests++;
            if (n != exp_q.size() || cyc != last_cyc + 1) begin
               fails++; $display("FAIL done_timing: got done at cyc=%0d after %0d writes expected cyc=%0d after %0d",
                                 cyc, n, last_cyc + 1, exp_q.size());
            end
            finished = 1;
         end
         if (abort_now) finished = 1;
         cyc++;
      end
      if (!finished) begin
         tests++; fails++;
         $display("FAIL timeout: got %0d writes in %0d cycles expected %0d", n, budget, exp_q.size());
      end
      @(negedge clk_i);
      start_i = 1'b0; abort_i = 1'b0; mem_ack_i = 1'b0; fifo_valid_i = 1'b0;
      #1;
      tests++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || mem_req_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
         fails++; $display("FAIL idle_after: got busy=%b done=%b req=%b pop=%b expected all 0",
                           busy_o, done_o, mem_req_o, fifo_pop_o);
      end
      r_writes = n; r_pops = pops; r_dones = dones;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; x0_i = '0; y0_i = '0; w_i = '0; h_i = '0;
      set_mask_i = 1'b0; chk_mask_i = 1'b0; fifo_data_i = 32'hFFFF_FFFF; fifo_valid_i = 1'b0; mem_ack_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      tests++;
      if ({busy_o, done_o, mem_req_o, fifo_pop_o, mem_chk_o} !== 5'b0 || mem_x_o !== '0 ||
          mem_y_o !== '0 || mem_data_o !== 16'h0) begin
         fails++; $display("FAIL reset_outputs: got busy=%b done=%b req=%b pop=%b x=%0d y=%0d d=%h expected all 0",
                           busy_o, done_o, mem_req_o, fifo_pop_o, mem_x_o, mem_y_o, mem_data_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1; fifo_valid_i = 1'b1; mem_ack_i = 1'b1;
      @(negedge clk_i); #1;
      tests++;
      if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
         fails++; $display("FAIL idle_no_start: got busy=%b req=%b pop=%b expected 0", busy_o, mem_req_o, fifo_pop_o);
      end
      fifo_valid_i = 1'b0; mem_ack_i = 1'b0;
   endtask

   task automatic test_2x2();
      src_q.delete(); src_q.push_back(32'h2222_1111); src_q.push_back(32'h4444_3333);
      run_xfer(0, 0, 2, 2, 0, 0, 4, 100, 100, -1, -1, -1, -1, -1);
      tests++;
      if (r_writes != 4 || r_pops != 2 || r_dones != 1) begin
         fails++; $display("FAIL 2x2_counts: got w=%0d p=%0d d=%0d expected 4 2 1", r_writes, r_pops, r_dones);
      end
   endtask

   task automatic test_odd_3x1();
      src_q.delete(); src_q.push_back(32'hBBBB_AAAA); src_q.push_back(32'hDDDD_CCCC);
      src_q.push_back(32'h1234_5678);
      run_xfer(10, 5, 3, 1, 0, 0, 4, 100, 100, -1, -1, -1, -1, -1);
      tests++;
      if (r_writes != 3 || r_pops != 2 || r_dones != 1) begin
         fails++; $display("FAIL 3x1_counts: got w=%0d p=%0d d=%0d expected 3 2 1", r_writes, r_pops, r_dones);
      end
   endtask

   task automatic test_wrap();
      src_q.delete(); src_q.push_back(32'h0B0B_0A0A); src_q.push_back(32'h0D0D_0C0C);
      run_xfer(1023, 511, 2, 2, 0, 1, 2, 80, 70, -1, -1, -1, -1, -1);
      tests++;
      if (r_writes != 4 || r_pops != 2 || r_dones != 1) begin
         fails++; $display("FAIL wrap_counts: got w=%0d p=%0d d=%0d expected 4 2 1", r_writes, r_pops, r_dones);
      end
   endtask

   task automatic test_full_row_mask();
      src_q.delete(); src_q.push_back(32'h0001_0001);
      for (int i = 1; i < 512; i++) src_q.push_back($urandom);
      run_xfer(100, 7, 0, 1, 1, 1, 4, 100, 100, -1, -1, -1, -1, -1);
      tests++;
      if (r_writes != 1024 || r_pops != 512 || r_dones != 1) begin
         fails++; $display("FAIL full_row_counts: got w=%0d p=%0d d=%0d expected 1024 512 1", r_writes, r_pops, r_dones);
      end
   endtask

   task automatic test_stalls();
      src_q.delete();
      for (int i = 0; i < 8; i++) src_q.push_back($urandom);
      run_xfer(20, 30, 5, 3, 0, 0, 1, 100, 100, 6, 8, 12, 16, -1);
      tests++;
      if (r_writes != 15 || r_pops != 8 || r_dones != 1) begin
         fails++; $display("FAIL stall_counts: got w=%0d p=%0d d=%0d expected 15 8 1", r_writes, r_pops, r_dones);
      end
   endtask

   task automatic test_random();
      int w, h, wn, hn, np;
      for (int it = 0; it < 10; it++) begin
         w = ($urandom_range(3) == 0) ? 1024 + $urandom_range(1, 5) : $urandom_range(1, 7);
         h = ($urandom_range(3) == 0) ? 512 + $urandom_range(1, 4) : $urandom_range(1, 5);
         wn = ((w - 1) & 1023) + 1;
         hn = ((h - 1) & 511) + 1;
         np = (wn * hn + 1) / 2;
         src_q.delete();
         for (int i = 0; i <= np; i++) src_q.push_back($urandom);
         run_xfer(1018 + $urandom_range(5), 508 + $urandom_range(3), w, h, 1'($urandom), 1'($urandom),
                  $urandom_range(1, 4), $urandom_range(40, 100), $urandom_range(40, 100), -1, -1, -1, -1, -1);
         tests++;
         if (r_writes != wn * hn || r_pops != np || r_dones != 1) begin
            fails++; $display("FAIL random%0d_counts: got w=%0d p=%0d d=%0d expected %0d %0d 1",
                              it, r_writes, r_pops, r_dones, wn * hn, np);
         end
      end
   endtask

   task automatic test_abort();
      src_q.delete(); src_q.push_back(32'h2222_1111); src_q.push_back(32'h4444_3333);
      run_xfer(4, 4, 4, 1, 0, 0, 4, 100, 100, -1, -1, -1, -1, 3);
      tests++;
      if (r_writes != 3 || r_pops != 1 || r_dones != 0) begin
         fails++; $display("FAIL abort_counts: got w=%0d p=%0d d=%0d expected 3 1 0", r_writes, r_pops, r_dones);
      end
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk_i);
      x0_i = '0; y0_i = '0; w_i = (X_W+1)'(2); h_i = (Y_W+1)'(2);
      start_i = 1'b1; abort_i = 1'b1; fifo_valid_i = 1'b1; fifo_data_i = 32'h5555_AAAA; mem_ack_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; abort_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || fifo_pop_o !== 1'b0) begin
            fails++; $display("FAIL start_abort_idle: got busy=%b req=%b pop=%b expected 0",
                              busy_o, mem_req_o, fifo_pop_o);
         end
         @(negedge clk_i);
      end
      fifo_valid_i = 1'b0; mem_ack_i = 1'b0;
   endtask

   task automatic test_async_reset();
      @(negedge clk_i);
      x0_i = X_W'(3); y0_i = Y_W'(3); w_i = (X_W+1)'(4); h_i = (Y_W+1)'(4);
      set_mask_i = 1'b1; chk_mask_i = 1'b1; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; fifo_valid_i = 1'b1; fifo_data_i = 32'h7777_6666; mem_ack_i = 1'b1;
      repeat (4) @(negedge clk_i);
      #1;
      tests++;
      if (busy_o !== 1'b1 || mem_req_o !== 1'b1) begin
         fails++; $display("FAIL pre_reset_active: got busy=%b req=%b expected 1 1", busy_o, mem_req_o);
      end
      #1 rst_ni = 1'b0;
      #1;
      tests++;
      if ({busy_o, done_o, mem_req_o, fifo_pop_o, mem_chk_o} !== 5'b0 || mem_x_o !== '0 ||
          mem_y_o !== '0 || mem_data_o !== 16'h0) begin
         fails++; $display("FAIL async_reset: got busy=%b done=%b req=%b pop=%b chk=%b x=%0d y=%0d d=%h expected all 0",
                           busy_o, done_o, mem_req_o, fifo_pop_o, mem_chk_o, mem_x_o, mem_y_o, mem_data_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1; fifo_valid_i = 1'b0; mem_ack_i = 1'b0; set_mask_i = 1'b0; chk_mask_i = 1'b0;
      src_q.delete();
      for (int i = 0; i < 3; i++) src_q.push_back($urandom);
      run_xfer(500, 200, 3, 2, 0, 0, 2, 90, 90, -1, -1, -1, -1, -1);
      tests++;
      if (r_writes != 6 || r_pops != 3 || r_dones != 1) begin
         fails++; $display("FAIL post_reset_counts: got w=%0d p=%0d d=%0d expected 6 3 1", r_writes, r_pops, r_dones);
      end
   endtask

   initial begin
      test_reset();
      test_2x2();
      test_odd_3x1();
      test_wrap();
      test_full_row_mask();
      test_stalls();
      test_random();
      test_abort();
      test_start_abort_idle();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
